// File: rtl/pc_predict_unit_pkg.sv
// Shared types for the fetch-PC predictor: counter encoding, default BTB entry layout
// and the saturating counter helpers.
package pc_pkg;

  localparam int PC_W          = 32;
  localparam int BTB_IDX_W_DEF = 4;

  typedef logic [PC_W-1:0] word_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  // Entry layout for the default 32-bit, 16-entry build.
  typedef struct packed {
    logic                            valid;
    logic [PC_W-BTB_IDX_W_DEF-3:0]   tag;
    word_t                           target;
    ctr_t                            ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    case (c)
      STRONG_NT: return WEAK_NT;
      WEAK_NT:   return WEAK_T;
      default:   return STRONG_T;
    endcase
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    case (c)
      STRONG_T: return WEAK_T;
      WEAK_T:   return WEAK_NT;
      default:  return STRONG_NT;
    endcase
  endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// Fetch-PC bus between hazard/EX control (master) and the PC predict unit (slave).
interface pc_predict_unit_if #(
  parameter int WORD_W = 32
);
  logic              pcWEN;
  logic              flush;
  logic [WORD_W-1:0] flush_pc;
  logic              btb_upd_en;
  logic [WORD_W-1:0] btb_upd_pc;
  logic [WORD_W-1:0] btb_upd_target;
  logic              btb_upd_taken;
  logic [WORD_W-1:0] pc_out;
  logic [WORD_W-1:0] pc_plus4;
  logic              pred_taken;
  logic [WORD_W-1:0] pred_target;
  logic              misalign_err;

  modport master (
    output pcWEN, flush, flush_pc, btb_upd_en, btb_upd_pc, btb_upd_target, btb_upd_taken,
    input  pc_out, pc_plus4, pred_taken, pred_target, misalign_err
  );

  modport slave (
    input  pcWEN, flush, flush_pc, btb_upd_en, btb_upd_pc, btb_upd_target, btb_upd_taken,
    output pc_out, pc_plus4, pred_taken, pred_target, misalign_err
  );
endinterface

// File: rtl/pc_predict_unit_btb_table.sv
// Direct-mapped branch target buffer: one combinational read port for fetch lookup and
// one training write port from EX. Reads return pre-write contents.
module btb_table
  import pc_pkg::*;
#(
  parameter  int WORD_W    = 32,
  parameter  int BTB_DEPTH = 16,
  localparam int IDX_W     = $clog2(BTB_DEPTH),
  localparam int TAG_W     = WORD_W - IDX_W - 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  output logic              rd_hit_o,
  output ctr_t              rd_ctr_o,
  output logic [WORD_W-1:0] rd_target_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [WORD_W-1:0] wr_target_i,
  input  logic              wr_taken_i
);

  logic              valid_q  [BTB_DEPTH];
  ctr_t              ctr_q    [BTB_DEPTH];
  logic [TAG_W-1:0]  tag_q    [BTB_DEPTH];
  logic [WORD_W-1:0] target_q [BTB_DEPTH];

  logic wr_hit;
  logic alloc;
  logic ctr_we;
  logic tgt_we;
  ctr_t ctr_d;

  assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_ctr_o    = ctr_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];

  assign wr_hit = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

  always_comb begin
    alloc  = 1'b0;
    ctr_we = 1'b0;
    tgt_we = 1'b0;
    ctr_d  = ctr_q[wr_idx_i];
    if (wr_en_i) begin
      if (wr_hit) begin
        ctr_we = 1'b1;
        tgt_we = wr_taken_i;
        ctr_d  = wr_taken_i ? ctr_inc(ctr_q[wr_idx_i]) : ctr_dec(ctr_q[wr_idx_i]);
      end else if (wr_taken_i) begin
        // A taken miss evicts whatever lives at this index.
        alloc  = 1'b1;
        ctr_we = 1'b1;
        tgt_we = 1'b1;
        ctr_d  = WEAK_T;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WEAK_NT;
      end
    end else begin
      if (alloc)  valid_q[wr_idx_i] <= 1'b1;
      if (ctr_we) ctr_q[wr_idx_i]   <= ctr_d;
    end
  end

  // Tag and target are qualified by valid, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (alloc)  tag_q[wr_idx_i]    <= wr_tag_i;
    if (tgt_we) target_q[wr_idx_i] <= wr_target_i;
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with redirect > predicted-target > PC+4 selection and a BTB.
// Optional macro ALIGN_CHK_EN: misaligned redirects trap to EXC_VEC and raise misalign_err.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int                WORD_W    = 32,
  parameter logic [WORD_W-1:0] RESET_PC  = '0,
  parameter int                BTB_DEPTH = 16,
  parameter logic [WORD_W-1:0] EXC_VEC   = 32'h8000_0180
) (
  input logic              CLK,
  input logic              nRST,
  pc_predict_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  logic [WORD_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] redirect_pc;
  logic              misalign_flush;
  logic              upd_drop;
  logic              rd_hit;
  ctr_t              rd_ctr;
  logic [WORD_W-1:0] rd_target;
  logic              unused_upd_pc_lsb;

  assign unused_upd_pc_lsb = &{1'b0, bus.btb_upd_pc[1:0]};

`ifdef ALIGN_CHK_EN
  assign misalign_flush = bus.flush && (bus.flush_pc[1:0] != 2'b00);
  assign upd_drop       = (bus.btb_upd_target[1:0] != 2'b00);
`else
  assign misalign_flush = 1'b0;
  assign upd_drop       = 1'b0;
`endif

  btb_table #(
    .WORD_W    (WORD_W),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .CLK         (CLK),
    .nRST        (nRST),
    .rd_idx_i    (pc_q[IDX_W+1:2]),
    .rd_tag_i    (pc_q[WORD_W-1:IDX_W+2]),
    .rd_hit_o    (rd_hit),
    .rd_ctr_o    (rd_ctr),
    .rd_target_o (rd_target),
    .wr_en_i     (bus.btb_upd_en && !upd_drop),
    .wr_idx_i    (bus.btb_upd_pc[IDX_W+1:2]),
    .wr_tag_i    (bus.btb_upd_pc[WORD_W-1:IDX_W+2]),
    .wr_target_i (bus.btb_upd_target),
    .wr_taken_i  (bus.btb_upd_taken)
  );

  assign pc_plus4         = pc_q + WORD_W'(4);
  assign bus.pc_out       = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.pred_taken   = rd_hit && rd_ctr[1];
  assign bus.pred_target  = rd_target;
  assign bus.misalign_err = misalign_q;

  assign redirect_pc = misalign_flush ? EXC_VEC : bus.flush_pc;
  assign misalign_d  = misalign_flush;

  // A redirect loads even while fetch is stalled.
  always_comb begin
    pc_d = pc_q;
    if (bus.flush)      pc_d = redirect_pc;
    else if (bus.pcWEN) pc_d = bus.pred_taken ? rd_target : pc_plus4;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: reset, stall/redirect, BTB training, aliasing,
// counter saturation, PC wrap, alignment handling and asynchronous reset.
module tb_pc_predict_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0040;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0180;

  logic CLK;
  logic nRST;
  int   total = 0;
  int   bad   = 0;

  pc_predict_unit_if #(.WORD_W(32)) bus ();

  pc_predict_unit #(
    .WORD_W    (32),
    .RESET_PC  (RESET_PC),
    .BTB_DEPTH (16),
    .EXC_VEC   (EXC_VEC)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.flush    = 1'b1;
    bus.flush_pc = pc;
    step();
    bus.flush    = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input int n);
    bus.btb_upd_en     = 1'b1;
    bus.btb_upd_pc     = pc;
    bus.btb_upd_target = tgt;
    bus.btb_upd_taken  = tk;
    for (int i = 0; i < n; i++) step();
    bus.btb_upd_en     = 1'b0;
  endtask

  initial begin
    nRST               = 1'b1;
    bus.pcWEN          = 1'b0;
    bus.flush          = 1'b0;
    bus.flush_pc       = '0;
    bus.btb_upd_en     = 1'b0;
    bus.btb_upd_pc     = '0;
    bus.btb_upd_target = '0;
    bus.btb_upd_taken  = 1'b0;
    #1 nRST = 1'b0;
    #11;
    chk("rst_pc", bus.pc_out, RESET_PC);
    chk("rst_pred", {31'b0, bus.pred_taken}, 32'd0);
    chk("rst_mis", {31'b0, bus.misalign_err}, 32'd0);
    chk("rst_plus4", bus.pc_plus4, 32'h44);

    nRST      = 1'b1;
    bus.pcWEN = 1'b1;
    step(); chk("seq_44", bus.pc_out, 32'h44);
    step(); chk("seq_48", bus.pc_out, 32'h48);
    step(); chk("seq_4c", bus.pc_out, 32'h4C);

    bus.pcWEN = 1'b0;
    redirect(32'h100);
    chk("redir_100", bus.pc_out, 32'h100);
    step(); step(); step();
    chk("stall_hold", bus.pc_out, 32'h100);
    redirect(32'h200);
    chk("stall_flush", bus.pc_out, 32'h200);

    // Flush and training in the same cycle
    bus.flush          = 1'b1;
    bus.flush_pc       = 32'h104;
    bus.btb_upd_en     = 1'b1;
    bus.btb_upd_pc     = 32'h104;
    bus.btb_upd_target = 32'h300;
    bus.btb_upd_taken  = 1'b1;
    step();
    bus.flush      = 1'b0;
    bus.btb_upd_en = 1'b0;
    chk("flush_upd_pc", bus.pc_out, 32'h104);
    chk("alloc_pred", {31'b0, bus.pred_taken}, 32'd1);
    chk("alloc_tgt", bus.pred_target, 32'h300);
    bus.pcWEN = 1'b1;
    step(); chk("follow_pred", bus.pc_out, 32'h300);
    bus.pcWEN = 1'b0;

    // Three not-taken: 10 -> 01 -> 00 -> 00
    train(32'h104, 32'h300, 1'b0, 3);
    redirect(32'h104);
    chk("nt_pred", {31'b0, bus.pred_taken}, 32'd0);
    bus.pcWEN = 1'b1;
    step(); chk("nt_fall", bus.pc_out, 32'h108);
    bus.pcWEN = 1'b0;
    train(32'h104, 32'h300, 1'b1, 1);
    redirect(32'h104);
    chk("weak_nt_pred", {31'b0, bus.pred_taken}, 32'd0);
    train(32'h104, 32'h300, 1'b1, 1);
    chk("weak_t_pred", {31'b0, bus.pred_taken}, 32'd1);
    chk("weak_t_tgt", bus.pred_target, 32'h300);

    // Write and lookup at the same index: lookup uses the old target
    bus.pcWEN = 1'b1;
    train(32'h104, 32'h340, 1'b1, 1);
    chk("rd_before_wr", bus.pc_out, 32'h300);
    bus.pcWEN = 1'b0;
    redirect(32'h104);
    chk("tgt_update", bus.pred_target, 32'h340);

    // Alias at index 1
    train(32'h144, 32'h500, 1'b1, 1);
    redirect(32'h104);
    chk("alias_old", {31'b0, bus.pred_taken}, 32'd0);
    redirect(32'h144);
    chk("alias_new", {31'b0, bus.pred_taken}, 32'd1);
    chk("alias_tgt", bus.pred_target, 32'h500);

    // Five taken from empty then one not-taken: saturating leaves 10
    train(32'h208, 32'h600, 1'b1, 5);
    train(32'h208, 32'h600, 1'b0, 1);
    redirect(32'h208);
    chk("sat_pred", {31'b0, bus.pred_taken}, 32'd1);
    train(32'h208, 32'h600, 1'b0, 1);
    chk("sat_dec", {31'b0, bus.pred_taken}, 32'd0);

    redirect(32'hFFFF_FFFC);
    chk("wrap_plus4", bus.pc_plus4, 32'h0);
    bus.pcWEN = 1'b1;
    step(); chk("wrap_pc", bus.pc_out, 32'h0);
    bus.pcWEN = 1'b0;

    redirect(32'h102);
`ifdef ALIGN_CHK_EN
    chk("align_pc", bus.pc_out, EXC_VEC);
    chk("align_err", {31'b0, bus.misalign_err}, 32'd1);
`else
    chk("align_pc", bus.pc_out, 32'h102);
    chk("align_err", {31'b0, bus.misalign_err}, 32'd0);
`endif
    step();
    chk("align_err_end", {31'b0, bus.misalign_err}, 32'd0);

    // Asynchronous reset between edges
    nRST = 1'b0;
    #2;
    chk("arst_pc", bus.pc_out, RESET_PC);
    chk("arst_mis", {31'b0, bus.misalign_err}, 32'd0);
    nRST = 1'b1;
    redirect(32'h144);
    chk("arst_btb", {31'b0, bus.pred_taken}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
